// File: rtl/VX_gpu_pkg.sv
// Shared writeback packet layout and arbiter sizing helpers.
// Used by vx_writeback_arbiter (optional macro VX_WB_ARB_LOCK_EN).
package VX_gpu_pkg;

  localparam int UUID_WIDTH  = 44;
  localparam int ISSUE_WIS_W = 2;
  localparam int NUM_THREADS = 4;
  localparam int XLEN        = 32;
  localparam int NR_BITS     = 6;
  localparam int CU_WIS_W    = 4;

  localparam int WB_DATAW = UUID_WIDTH + ISSUE_WIS_W
                          + NUM_THREADS + XLEN + NR_BITS
                          + NUM_THREADS * XLEN + 2
                          + CU_WIS_W;

  typedef struct packed {
    logic [UUID_WIDTH-1:0]       uuid;
    logic [ISSUE_WIS_W-1:0]      wis;
    logic [NUM_THREADS-1:0]      tmask;
    logic [XLEN-1:0]             PC;
    logic [NR_BITS-1:0]          rd;
    logic [NUM_THREADS*XLEN-1:0] data;
    logic                        sop;
    logic                        eop;
    logic [CU_WIS_W-1:0]         cu_id;
  } data_t;

  // Flag positions inside a flat packet vector
  localparam int WB_EOP_BIT = CU_WIS_W;
  localparam int WB_SOP_BIT = CU_WIS_W + 1;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/vx_writeback_arbiter_rr.sv
// Round-robin arbiter with an optional hold on one index.
// Owns the priority pointer; grant is combinational from req.
module vx_rr_arbiter
  import VX_gpu_pkg::*;
#(
  parameter int NUM_REQS = 4,
  parameter int IDXW     = idx_w(NUM_REQS)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [NUM_REQS-1:0] req_i,
  input  logic                lock_en_i,
  input  logic [IDXW-1:0]     lock_idx_i,
  output logic [NUM_REQS-1:0] grant_o,
  output logic [IDXW-1:0]     grant_idx_o,
  output logic                grant_valid_o
);

  if (NUM_REQS == 1) begin : g_single
    logic unused_ok;
    assign unused_ok = ^{clk_i, rst_ni,
                         lock_en_i, lock_idx_i};
    assign grant_o       = req_i;
    assign grant_idx_o   = '0;
    assign grant_valid_o = req_i[0];
  end else begin : g_multi
    localparam logic [IDXW:0] NR =
      (IDXW+1)'(NUM_REQS);

    logic [IDXW-1:0] ptr_q, ptr_d;
    logic [IDXW:0]   pos;
    logic [IDXW:0]   nxt;
    logic            hit;

    always_comb begin
      grant_o     = '0;
      grant_idx_o = '0;
      hit         = 1'b0;
      pos         = '0;
      if (lock_en_i) begin
        if (req_i[lock_idx_i]) begin
          hit         = 1'b1;
          grant_idx_o = lock_idx_i;
        end
      end else begin
        for (int k = 0; k < NUM_REQS; k++) begin
          pos = {1'b0, ptr_q} + (IDXW+1)'(k);
          if (pos >= NR) pos = pos - NR;
          if (!hit && req_i[pos[IDXW-1:0]]) begin
            hit         = 1'b1;
            grant_idx_o = pos[IDXW-1:0];
          end
        end
      end
      grant_o[grant_idx_o] = hit;
      grant_valid_o        = hit;
    end

    always_comb begin
      nxt = {1'b0, grant_idx_o} + (IDXW+1)'(1);
      if (nxt >= NR) nxt = '0;
      ptr_d = grant_valid_o ? nxt[IDXW-1:0] : ptr_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) ptr_q <= '0;
      else         ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/vx_writeback_arbiter.sv
// Merges execute-unit commit streams into one registered writeback.
// Define VX_WB_ARB_LOCK_EN to keep sop..eop bursts contiguous.
module vx_writeback_arbiter
  import VX_gpu_pkg::*;
#(
  parameter int NUM_INPUTS = 4,
  parameter int DATAW      = WB_DATAW
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [NUM_INPUTS-1:0]       in_valid,
  input  logic [NUM_INPUTS*DATAW-1:0] in_data,
  output logic [NUM_INPUTS-1:0]       in_ready,
  output logic                        out_valid,
  output logic [DATAW-1:0]            out_data
);

  localparam int IDXW = idx_w(NUM_INPUTS);

  logic [NUM_INPUTS-1:0] req;
  logic [NUM_INPUTS-1:0] grant;
  logic [IDXW-1:0]       gidx;
  logic                  gvld;
  logic                  lock_en;
  logic [IDXW-1:0]       lock_idx;
  logic [DATAW-1:0]      gpkt;

  logic                  out_valid_q, out_valid_d;
  logic [DATAW-1:0]      out_data_q, out_data_d;

  // Nothing may be accepted while reset is held
  assign req = in_valid & {NUM_INPUTS{reset_n}};

  vx_rr_arbiter #(
    .NUM_REQS (NUM_INPUTS),
    .IDXW     (IDXW)
  ) u_rr (
    .clk_i         (clk),
    .rst_ni        (reset_n),
    .req_i         (req),
    .lock_en_i     (lock_en),
    .lock_idx_i    (lock_idx),
    .grant_o       (grant),
    .grant_idx_o   (gidx),
    .grant_valid_o (gvld)
  );

  assign in_ready = grant;
  assign gpkt     = in_data[gidx*DATAW +: DATAW];

`ifdef VX_WB_ARB_LOCK_EN
  logic            lock_q, lock_d;
  logic [IDXW-1:0] lock_idx_q, lock_idx_d;

  always_comb begin
    lock_d     = lock_q;
    lock_idx_d = lock_idx_q;
    if (gvld) begin
      lock_d = !gpkt[WB_EOP_BIT];
      if (!gpkt[WB_EOP_BIT]) lock_idx_d = gidx;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
    end else begin
      lock_q     <= lock_d;
      lock_idx_q <= lock_idx_d;
    end
  end

  assign lock_en  = lock_q;
  assign lock_idx = lock_idx_q;
`else
  assign lock_en  = 1'b0;
  assign lock_idx = '0;
`endif

  always_comb begin
    out_valid_d = gvld;
    out_data_d  = gvld ? gpkt : out_data_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

`ifndef SYNTHESIS
  logic [NUM_INPUTS-1:0] open_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      open_q <= '0;
    end else if (gvld) begin
      if (gpkt[WB_EOP_BIT])      open_q[gidx] <= 1'b0;
      else if (gpkt[WB_SOP_BIT]) open_q[gidx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset_n) begin
      assert ($onehot0(in_ready))
        else $error("in_ready not onehot0");
      if (gvld && gpkt[WB_EOP_BIT])
        assert (gpkt[WB_SOP_BIT] || open_q[gidx])
          else $error("eop without sop");
    end
  end
`endif

endmodule

// File: tb/tb_vx_writeback_arbiter.sv
// Randomised and directed bench for vx_writeback_arbiter.
// Reference model: round-robin search with modulo arithmetic.
module tb_vx_writeback_arbiter;
  import VX_gpu_pkg::*;

  localparam int N = 4;
  localparam int W = WB_DATAW;

  logic           clk = 1'b0;
  logic           reset_n = 1'b1;
  logic [N-1:0]   vld;
  logic [N-1:0]   in_ready;
  logic [N*W-1:0] in_data;
  logic           out_valid;
  logic [W-1:0]   out_data;
  data_t          pkt [N];

  logic           vld1, rdy1, ov1;
  logic [W-1:0]   dat1, od1;

  int n_cmp = 0;
  int n_bad = 0;

  int         ptr_m;
  bit         lock_m;
  int         lidx_m;
  bit         ov_m;
  logic [W-1:0] od_m;

  always #5 clk = ~clk;

  always_comb
    for (int i = 0; i < N; i++)
      in_data[i*W +: W] = pkt[i];

  vx_writeback_arbiter #(.NUM_INPUTS(N)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (vld),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data)
  );

  vx_writeback_arbiter #(.NUM_INPUTS(1)) dut1 (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (vld1),
    .in_data   (dat1),
    .in_ready  (rdy1),
    .out_valid (ov1),
    .out_data  (od1)
  );

  function automatic data_t rand_pkt(input bit eop);
    logic [W-1:0] r;
    data_t p;
    r = '0;
    for (int k = 0; k < (W + 31) / 32; k++)
      r = {r[W-33:0], 32'($urandom)};
    p = data_t'(r);
    p.sop = 1'b1;
    p.eop = eop;
    return p;
  endfunction

  function automatic int model_grant(input logic [N-1:0] v);
    if (lock_m) return v[lidx_m] ? lidx_m : -1;
    for (int k = 0; k < N; k++)
      if (v[(ptr_m + k) % N]) return (ptr_m + k) % N;
    return -1;
  endfunction

  function automatic logic [N-1:0] exp_ready(input int g);
    logic [N-1:0] r;
    r = '0;
    if (g >= 0) r[g] = 1'b1;
    return r;
  endfunction

  task automatic model_reset();
    ptr_m  = 0;
    lock_m = 1'b0;
    lidx_m = 0;
    ov_m   = 1'b0;
    od_m   = '0;
  endtask

  task automatic clk_step(output int g);
    g = model_grant(vld);
    @(posedge clk);
    if (g >= 0) begin
      ov_m  = 1'b1;
      od_m  = pkt[g];
      ptr_m = (g + 1) % N;
`ifdef VX_WB_ARB_LOCK_EN
      lock_m = !pkt[g].eop;
      if (!pkt[g].eop) lidx_m = g;
`endif
    end else begin
      ov_m = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    vld     = '0;
    vld1    = 1'b0;
    @(posedge clk);
    #2 reset_n = 1'b1;
    model_reset();
    @(negedge clk);
  endtask

  task automatic test_reset();
    int g;
    vld  = '1;
    vld1 = 1'b1;
    dat1 = W'(rand_pkt(1'b1));
    for (int i = 0; i < N; i++) pkt[i] = rand_pkt(1'b1);
    #1 reset_n = 1'b0;
    for (int r = 0; r < 2; r++) begin
      #1;
      n_cmp++;
      if (in_ready !== '0) begin
        n_bad++;
        $display("FAIL rst_ready: got %b expected 0", in_ready);
      end
      n_cmp++;
      if (out_valid !== 1'b0 || out_data !== '0) begin
        n_bad++;
        $display("FAIL rst_out: got v=%b d=%h expected 0",
                 out_valid, out_data);
      end
      n_cmp++;
      if (rdy1 !== 1'b0 || ov1 !== 1'b0) begin
        n_bad++;
        $display("FAIL rst_n1: got r=%b v=%b expected 0", rdy1, ov1);
      end
      if (r == 0) @(posedge clk);
    end
    #1 reset_n = 1'b1;
    model_reset();
    @(negedge clk);
    #1;
    n_cmp++;
    if (in_ready !== 4'b0001) begin
      n_bad++;
      $display("FAIL first_grant: got %b expected 0001", in_ready);
    end
    vld1 = 1'b0;
    clk_step(g);
  endtask

  task automatic test_single_source();
    int g;
    data_t o;
    do_reset();
    pkt[2]    = rand_pkt(1'b1);
    pkt[2].rd = 6'd5;
    vld       = 4'b0100;
    #1;
    n_cmp++;
    if (in_ready !== 4'b0100) begin
      n_bad++;
      $display("FAIL single_ready: got %b expected 0100", in_ready);
    end
    clk_step(g);
    vld = '0;
    #1;
    o = data_t'(out_data);
    n_cmp++;
    if (out_valid !== 1'b1 || o.rd !== 6'd5) begin
      n_bad++;
      $display("FAIL single_out: got v=%b rd=%0d expected v=1 rd=5",
               out_valid, o.rd);
    end
    n_cmp++;
    if (out_data !== od_m) begin
      n_bad++;
      $display("FAIL single_data: got %h expected %h", out_data, od_m);
    end
    clk_step(g);
    #1;
    n_cmp++;
    if (out_valid !== 1'b0 || out_data !== od_m) begin
      n_bad++;
      $display("FAIL single_idle: got v=%b d=%h expected v=0 d=%h",
               out_valid, out_data, od_m);
    end
  endtask

  task automatic test_all_valid();
    int g;
    logic [N-1:0] er;
    do_reset();
    for (int i = 0; i < N; i++) pkt[i] = rand_pkt(1'b1);
    for (int c = 0; c <= 8; c++) begin
      vld = (c < 8) ? '1 : '0;
      er  = (c < 8) ? N'(1 << (c % N)) : '0;
      #1;
      n_cmp++;
      if (in_ready !== er) begin
        n_bad++;
        $display("FAIL rot_ready c%0d: got %b expected %b",
                 c, in_ready, er);
      end
      n_cmp++;
      if (out_valid !== (c >= 1)) begin
        n_bad++;
        $display("FAIL rot_valid c%0d: got %b expected %b",
                 c, out_valid, (c >= 1));
      end
      n_cmp++;
      if (out_data !== od_m) begin
        n_bad++;
        $display("FAIL rot_data c%0d: got %h expected %h",
                 c, out_data, od_m);
      end
      clk_step(g);
      if (g >= 0) pkt[g] = rand_pkt(1'b1);
    end
  endtask

  task automatic test_wrap();
    int g;
    do_reset();
    pkt[1] = rand_pkt(1'b1);
    vld    = 4'b0010;
    clk_step(g);
    pkt[1] = rand_pkt(1'b1);
    pkt[3] = rand_pkt(1'b1);
    vld    = 4'b1010;
    #1;
    n_cmp++;
    if (in_ready !== 4'b1000) begin
      n_bad++;
      $display("FAIL wrap_first: got %b expected 1000", in_ready);
    end
    clk_step(g);
    vld = 4'b0010;
    #1;
    n_cmp++;
    if (in_ready !== 4'b0010) begin
      n_bad++;
      $display("FAIL wrap_second: got %b expected 0010", in_ready);
    end
    n_cmp++;
    if (out_valid !== 1'b1 || out_data !== W'(pkt[3])) begin
      n_bad++;
      $display("FAIL wrap_data: got %h expected %h",
               out_data, W'(pkt[3]));
    end
    clk_step(g);
    vld = '1;
    #1;
    n_cmp++;
    if (in_ready !== 4'b0100) begin
      n_bad++;
      $display("FAIL wrap_ptr: got %b expected 0100", in_ready);
    end
    vld = '0;
    clk_step(g);
  endtask

`ifdef VX_WB_ARB_LOCK_EN
  task automatic test_lock();
    int g;
    do_reset();
    pkt[0] = rand_pkt(1'b0);
    pkt[1] = rand_pkt(1'b1);
    vld    = 4'b0011;
    #1;
    n_cmp++;
    if (in_ready !== 4'b0001) begin
      n_bad++;
      $display("FAIL lock_sop: got %b expected 0001", in_ready);
    end
    clk_step(g);
    vld = 4'b0010;
    #1;
    n_cmp++;
    if (in_ready !== 4'b0000) begin
      n_bad++;
      $display("FAIL lock_hold: got %b expected 0000", in_ready);
    end
    clk_step(g);
    pkt[0]     = rand_pkt(1'b1);
    pkt[0].sop = 1'b0;
    vld        = 4'b0011;
    #1;
    n_cmp++;
    if (in_ready !== 4'b0001) begin
      n_bad++;
      $display("FAIL lock_eop: got %b expected 0001", in_ready);
    end
    clk_step(g);
    vld = 4'b0010;
    #1;
    n_cmp++;
    if (in_ready !== 4'b0010) begin
      n_bad++;
      $display("FAIL lock_release: got %b expected 0010", in_ready);
    end
    vld = '0;
    clk_step(g);
  endtask
`endif

  task automatic test_reset_midburst();
    int g;
    do_reset();
    pkt[0] = rand_pkt(1'b0);
    vld    = 4'b0001;
    clk_step(g);
    pkt[1] = rand_pkt(1'b1);
    pkt[2] = rand_pkt(1'b1);
    vld    = 4'b0110;
    #1;
    n_cmp++;
    if (out_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL mid_pre: got %b expected 1", out_valid);
    end
    reset_n = 1'b0;
    #1;
    n_cmp++;
    if (out_valid !== 1'b0 || in_ready !== '0 || out_data !== '0) begin
      n_bad++;
      $display("FAIL mid_rst: got v=%b r=%b d=%h expected zeros",
               out_valid, in_ready, out_data);
    end
    @(posedge clk);
    #2 reset_n = 1'b1;
    model_reset();
    @(negedge clk);
    #1;
    n_cmp++;
    if (in_ready !== 4'b0010) begin
      n_bad++;
      $display("FAIL mid_after: got %b expected 0010", in_ready);
    end
    clk_step(g);
    vld = '0;
    #1;
    n_cmp++;
    if (out_valid !== 1'b1 || out_data !== W'(pkt[1])) begin
      n_bad++;
      $display("FAIL mid_data: got v=%b d=%h expected v=1 d=%h",
               out_valid, out_data, W'(pkt[1]));
    end
    clk_step(g);
  endtask

  task automatic test_random();
    int g, ge;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++)
        if (!vld[i] && $urandom_range(0, 2) != 0) begin
          vld[i] = 1'b1;
          pkt[i] = rand_pkt($urandom_range(0, 3) != 0);
        end
      ge = model_grant(vld);
      #1;
      n_cmp++;
      if (in_ready !== exp_ready(ge)) begin
        n_bad++;
        $display("FAIL rnd_ready c%0d: got %b expected %b",
                 c, in_ready, exp_ready(ge));
      end
      n_cmp++;
      if (out_valid !== ov_m || out_data !== od_m) begin
        n_bad++;
        $display("FAIL rnd_out c%0d: got v=%b d=%h expected v=%b d=%h",
                 c, out_valid, out_data, ov_m, od_m);
      end
      clk_step(g);
      if (g >= 0) vld[g] = 1'b0;
    end
    vld = '0;
    clk_step(g);
  endtask

  task automatic test_single_input();
    int g;
    logic [W-1:0] exp1 [5];
    do_reset();
    for (int c = 0; c <= 6; c++) begin
      if (c < 5) begin
        vld1    = 1'b1;
        dat1    = W'(rand_pkt(1'b1));
        exp1[c] = dat1;
      end else begin
        vld1 = 1'b0;
      end
      #1;
      n_cmp++;
      if (rdy1 !== vld1) begin
        n_bad++;
        $display("FAIL n1_ready c%0d: got %b expected %b", c, rdy1, vld1);
      end
      if (c >= 1 && c <= 5) begin
        n_cmp++;
        if (ov1 !== 1'b1 || od1 !== exp1[c-1]) begin
          n_bad++;
          $display("FAIL n1_out c%0d: got v=%b d=%h expected v=1 d=%h",
                   c, ov1, od1, exp1[c-1]);
        end
      end
      if (c == 6) begin
        n_cmp++;
        if (ov1 !== 1'b0) begin
          n_bad++;
          $display("FAIL n1_idle: got %b expected 0", ov1);
        end
      end
      clk_step(g);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    vld  = '0;
    vld1 = 1'b0;
    dat1 = '0;
    for (int i = 0; i < N; i++) pkt[i] = '0;
    model_reset();
    test_reset();
    test_single_source();
    test_all_valid();
    test_wrap();
`ifdef VX_WB_ARB_LOCK_EN
    test_lock();
`endif
    test_reset_midburst();
    test_random();
    test_single_input();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/vx_writeback_arbiter.md
# vx_writeback_arbiter

Merges the commit streams of the execute units (ALU, LSU, FPU, SFU) into the single per-cycle writeback stream that drives the register-file write port and scoreboard release. It sits directly upstream of the writeback interface and produces its master side: one registered packet per cycle, valid-only, no backpressure. Each input is a valid/ready handshake; fairness is round-robin, with an optional per-source burst lock that keeps multi-packet (sop..eop) results contiguous.

## Interface
- NUM_INPUTS, 4: number of commit sources; legal range 1..8.
- DATAW, WB_DATAW (package constant): packet width = UUID_WIDTH + ISSUE_WIS_W + NUM_THREADS + XLEN + NR_BITS + NUM_THREADS*XLEN + 2 + CU_WIS_W; field order uuid, wis, tmask, PC, rd, data, sop, eop, cu_id (MSB first).
- clk  input  1  clock; all state updates on its rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- in_valid  input  NUM_INPUTS  per-source packet valid.
- in_data  input  NUM_INPUTS*DATAW  per-source packet, source i at bits [i*DATAW +: DATAW].
- in_ready  output  NUM_INPUTS  per-source accept; one-hot or zero.
- out_valid  output  1  writeback valid (drives writeback master valid).
- out_data  output  DATAW  writeback packet (drives writeback master data).

## Operation
- Transfer on source i when in_valid[i] && in_ready[i]. Sources hold valid and data stable until accepted.
- Each cycle, grant the first valid source at or after the priority pointer ptr, scanning upward with wrap from NUM_INPUTS-1 to 0. in_ready[i]=1 only for the granted source. If no source is valid, no grant is made.
- in_ready is combinational from in_valid, ptr and lock state. It must not depend on out_* state, because the output never stalls.
- On grant of source g: ptr <= (g+1) mod NUM_INPUTS. With no grant, ptr holds.
- The output register loads the granted packet unchanged, and out_valid <= 1. With no grant, out_valid <= 0 and out_data holds its value.
- NUM_INPUTS=1: ptr is constant 0 and in_ready[0]=in_valid[0].
- All-valid case: grants rotate 0,1,2,3,0,… one per cycle, with no gap cycles.
- Reset (asserted at any time, including mid-burst): out_valid=0, out_data=0, ptr=0, lock cleared, in_ready=0 while reset_n=0. Any in-flight packet in the output register is dropped. The packet source re-presents after reset.

## Timing
- Latency: input accept cycle N produces out_valid=1 in cycle N+1.
- Throughput: one packet per cycle sustained.
- A source's wait before grant is at most NUM_INPUTS-1 cycles when the lock is compiled out.
- Reset deassertion is synchronised externally. The first grant is possible in the first clock edge after release.

## Configuration
- VX_WB_ARB_LOCK_EN defined: burst lock is enabled.
  - Granting a packet with eop=0 sets lock=1 and lock_idx=g.
  - While locked, only lock_idx may be granted. Other sources see in_ready=0 even if lock_idx is idle that cycle.
  - Granting lock_idx with eop=1 clears the lock. ptr advances normally on every grant.
  - Consequence: a multi-packet result appears contiguously on the output, apart from idle cycles.
- VX_WB_ARB_LOCK_EN undefined: no lock state; pure per-packet round-robin. sop/eop pass through untouched.
- In both builds, simulation-only assertions check:
  - in_ready is onehot0;
  - a source's eop=1 packet is preceded by its own sop=1 packet (a single sop=eop=1 packet also satisfies this).

## Structure
- VX_gpu_pkg holds WB_DATAW and a helper to compute the grant index width, $clog2(NUM_INPUTS) with a minimum of 1. The writeback data_t layout is defined there once and reused.
- One sub-module: vx_rr_arbiter, parameterised on NUM_REQS.
  - Inputs: request vector, lock enable, lock index.
  - Outputs: one-hot grant and grant index.
  - Owns ptr.
- The top level owns the output register and the lock flop.

## Test plan
- Single source: in_valid[2]=1 with rd=5 at cycle 0 -> in_ready=4'b0100 at cycle 0; out_valid=1, rd=5 at cycle 1; out_valid=0 at cycle 2.
- All four sources valid for 8 cycles from ptr=0 -> grant order 0,1,2,3,0,1,2,3; out_valid is high for 8 consecutive cycles starting at cycle 1.
- Sources 1 and 3 valid, ptr=2 -> grant 3 first, then 1 (wrap-around); ptr ends at 2.
- VX_WB_ARB_LOCK_EN: source 0 sends sop=1,eop=0, then one idle cycle, then eop=1, while source 1 is valid throughout -> source 1 is not granted until the cycle after source 0's eop packet is accepted.
- Reset pulse (reset_n=0 for 1 cycle) while out_valid=1 and locked -> out_valid=0 and in_ready=0 immediately; after release, the next grant follows ptr=0 order.
- NUM_INPUTS=1, continuous valid for 5 packets -> in_ready tracks in_valid; 5 consecutive out_valid cycles with data in input order.
